imem_fill: RTL and testbench
============================

Name: imem_fill

Overview:
- Responder on the L1 instruction-cache line-fill bus.
- Accepts a line read (b_rd, b_addr) from the I-cache and fetches the line as LINE_W/WORD_W sequential word reads from a word-wide backing memory port (m_*).
- Assembles the words into a line register and returns it with a one-cycle b_dv pulse.
- Sits between the hart's I-cache and the memory/bus interface.

Parameters:
- LINE_W, 256, line width in bits; must equal `imem_line; power of two, multiple of WORD_W.
- WORD_W, 64, backing memory word width in bits; power of two, >= 8.
- Derived localparams: BEATS = LINE_W/WORD_W; OFFS_LEN = log2(LINE_W/8); WOFFS_LEN = log2(WORD_W/8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- b_addr  in  64  requested address; only bits [63:OFFS_LEN] are used.
- b_rd  in  1  line read request, level; held high by the cache while it misses.
- b_data  out  LINE_W  assembled line; beat k occupies [k*WORD_W +: WORD_W].
- b_dv  out  1  line valid; a one-cycle pulse.
- m_addr  out  64  word address = {line base, beat, WOFFS_LEN zeros}.
- m_rd  out  1  word read request, level; held until m_dv.
- m_data  in  WORD_W  read word; sampled only when m_dv=1 and m_rd=1.
- m_dv  in  1  word valid; may assert in the same cycle m_rd first rises (zero-wait).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; beat counter and latched base go to 0.
  - b_dv, m_rd, busy and m_addr go to 0 immediately; b_data goes to 0.
  - A memory read outstanding at reset is abandoned; the backing memory shares rst.
- IDLE:
  - If b_rd=1 at the edge: latch base = b_addr[63:OFFS_LEN], set beat=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - m_rd=1, m_addr = {base, beat, 0}.
  - On m_dv, write m_data into b_data[beat*WORD_W +: WORD_W].
  - If m_dv on a beat other than BEATS-1: beat+1, stay in REQ; m_addr advances next cycle with no bubble.
  - If m_dv on beat BEATS-1: go to DONE.
- DONE (one cycle):
  - b_dv=1; b_data stable; m_rd=0.
  - Always go to IDLE. IDLE samples b_rd normally; the cache shows a hit by then, so no re-fill occurs.
- Abort, checked in REQ every cycle:
  - Condition: b_rd=0, or b_addr[63:OFFS_LEN] != base.
  - With m_dv=1 in the same cycle: discard the word, go to IDLE.
  - With m_dv=0: go to DRAIN.
  - Abort takes priority over completion on the last beat; no b_dv is produced.
- DRAIN:
  - m_rd=1 with m_addr held, until m_dv; then discard the word and go to IDLE.
  - b_rd is ignored in DRAIN. A new request is taken in IDLE on the next cycle.
- Latency with a zero-wait memory:
  - b_rd first seen high in cycle 0 -> REQ in cycles 1..BEATS -> b_dv in cycle BEATS+1.
  - Each memory wait cycle adds one cycle.
- b_data holds its last contents between fills. Partial fills corrupt it, but it is only meaningful while b_dv=1.
- Width rules:
  - beat counter is log2(BEATS) bits; no wrap is needed because the transition to DONE happens at BEATS-1.
  - For BEATS=1, the counter is 1 bit and held at 0.
- m_addr is registered-stable while m_rd=1; it never changes between the rise of m_rd and m_dv.

Decomposition:
- config.v: add `imem_fill_word` (WORD_W default) alongside `imem_line`.
- State encoding as localparams: IDLE=0, REQ=1, DONE=2, DRAIN=3, 2 bits.
- No sub-module: the FSM, beat counter and line register are one flat module.

Test Plan:
- Zero-wait fill: b_rd=1, b_addr=0x8000_0014, memory returns word k = 0x1111_1111_1111_1111*(k+1).
  - m_addr sequence 0x8000_0000, 0x8000_0008, 0x8000_0010, 0x8000_0018.
  - b_dv in cycle 5; b_data[63:0]=0x1111..., b_data[255:192]=0x4444....
- Wait states: memory m_dv 3 cycles after each m_rd beat -> m_addr held each wait; b_dv in cycle 17; exactly one b_dv pulse.
- Abort by drop: b_rd falls during beat 2 with m_dv=0 -> DRAIN holds m_addr=0x8000_0010 until m_dv; then IDLE; no b_dv.
- Abort by address change: b_addr changes to 0x8000_0040 during beat 1 with m_dv=1 -> word discarded; IDLE then a new fill with m_addr=0x8000_0040.
- Last-beat collision: abort condition and m_dv both on beat 3 -> IDLE, b_dv stays 0.
- Async reset mid-REQ: rst=1 between clock edges -> m_rd, busy and b_dv go to 0 before the next edge. After release with b_rd=1, fill restarts at beat 0.

Source files
------------

// File: rtl/imem_fill_pkg.sv
// Shared types and default widths for the I-cache line-fill responder.
package imem_fill_pkg;

    localparam int IMEM_LINE      = 256;
    localparam int IMEM_FILL_WORD = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/imem_fill.sv
// I-cache line-fill responder: fetches LINE_W/WORD_W words and returns the line with a b_dv pulse.
// Latency BEATS+1 cycles from b_rd with zero-wait memory; m_rd is held until m_dv, so memory stalls extend the fill.
module imem_fill
    import imem_fill_pkg::*;
#(
    parameter int LINE_W = IMEM_LINE,
    parameter int WORD_W = IMEM_FILL_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       b_addr,
    input  logic              b_rd,
    output logic [LINE_W-1:0] b_data,
    output logic              b_dv,
    output logic [63:0]       m_addr,
    output logic              m_rd,
    input  logic [WORD_W-1:0] m_data,
    input  logic              m_dv,
    output logic              busy
);

    localparam int BEATS     = LINE_W / WORD_W;
    localparam int OFFS_LEN  = $clog2(LINE_W / 8);
    localparam int WOFFS_LEN = $clog2(WORD_W / 8);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BASE_W    = 64 - OFFS_LEN;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t            state;
    state_t            state_nx;
    logic [BASE_W-1:0] base;
    logic [BEAT_W-1:0] beat;
    logic              abort;
    logic              last;
    logic              take;
    logic              unused_low;

    assign unused_low = ^b_addr[OFFS_LEN-1:0];

    // m_addr comes only from registers, so it cannot move while a word read is pending.
    assign m_addr = {base, {OFFS_LEN{1'b0}}} | (64'(beat) << WOFFS_LEN);

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        m_rd     = 1'b0;
        b_dv     = 1'b0;
        busy     = (state != IDLE);
        abort    = !b_rd || (b_addr[63:OFFS_LEN] != base);
        last     = (beat == LAST_BEAT);
        case (state)
            IDLE: begin
                if (b_rd) state_nx = REQ;
            end
            REQ: begin
                m_rd = 1'b1;
                // Abort wins over completion, so a stale line never pulses b_dv.
                if (abort) begin
                    state_nx = m_dv ? IDLE : DRAIN;
                end else if (m_dv) begin
                    take = 1'b1;
                    if (last) state_nx = DONE;
                end
            end
            DONE: begin
                b_dv     = 1'b1;
                state_nx = IDLE;
            end
            DRAIN: begin
                m_rd = 1'b1;
                if (m_dv) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            beat   <= '0;
            b_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && b_rd) begin
                base <= b_addr[63:OFFS_LEN];
                beat <= '0;
            end
            if (take) begin
                b_data[beat*WORD_W +: WORD_W] <= m_data;
                if (!last) beat <= beat + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_fill.sv
// Bench for imem_fill: a behavioural word memory with programmable wait states, checked against a line-level model.
`timescale 1ns/1ps
module tb_imem_fill;

    localparam int LINE_W = 256;
    localparam int WORD_W = 64;
    localparam int BEATS  = LINE_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [63:0]       b_addr = '0;
    logic              b_rd = 1'b0;
    logic [LINE_W-1:0] b_data;
    logic              b_dv;
    logic [63:0]       m_addr;
    logic              m_rd;
    logic [WORD_W-1:0] m_data = '0;
    logic              m_dv = 1'b0;
    logic              busy;

    imem_fill #(.LINE_W(LINE_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst),
        .b_addr(b_addr), .b_rd(b_rd), .b_data(b_data), .b_dv(b_dv),
        .m_addr(m_addr), .m_rd(m_rd), .m_data(m_data), .m_dv(m_dv),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int                cyc;
    int                dv_count;
    int                dv_cycle;
    logic [LINE_W-1:0] dv_data;
    logic [63:0]       addr_q[$];
    int                waits_q[$];
    int                fixed_wait = 0;
    bit                rand_waits = 0;
    logic [63:0]       salt = '0;
    bit                loaded = 0;
    int                wait_left = 0;
    bit                prev_wait = 0;
    logic [63:0]       prev_addr = '0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Backing memory contents: beat-index pattern, optionally scrambled by address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] pat;
        pat = 64'h1111_1111_1111_1111 * (64'(a[4:3]) + 64'd1);
        return pat ^ ({a[31:0], a[31:0]} & salt);
    endfunction

    function automatic logic [LINE_W-1:0] model_line(input logic [63:0] a);
        logic [LINE_W-1:0] l;
        logic [63:0]       lb;
        lb = {a[63:5], 5'b0};
        for (int k = 0; k < BEATS; k++) l[k*WORD_W +: WORD_W] = mem_word(lb + 64'(8 * k));
        return l;
    endfunction

    // One clock: memory answers the currently visible request, then the edge, then observe.
    task automatic step();
        if (m_rd) begin
            if (prev_wait) chk64("m_addr_held", m_addr, prev_addr);
            if (!loaded) begin
                wait_left = rand_waits ? int'($urandom_range(0, 3)) : fixed_wait;
                waits_q.push_back(wait_left);
                loaded = 1;
            end
            if (wait_left == 0) begin
                m_dv = 1'b1;
                m_data = mem_word(m_addr);
                addr_q.push_back(m_addr);
                loaded = 0;
                prev_wait = 0;
            end else begin
                m_dv = 1'b0;
                m_data = {$urandom, $urandom};
                wait_left--;
                prev_wait = 1;
                prev_addr = m_addr;
            end
        end else begin
            m_dv = 1'b0;
            m_data = {$urandom, $urandom};
            loaded = 0;
            prev_wait = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (b_dv) begin
            dv_count++;
            dv_cycle = cyc;
            dv_data = b_data;
        end
    endtask

    task automatic clear();
        cyc = 0;
        dv_count = 0;
        dv_cycle = -1;
        dv_data = '0;
        addr_q.delete();
        waits_q.delete();
    endtask

    // Runs an already-requested fill to completion and checks it against the model.
    task automatic finish_fill(input logic [63:0] a, input string tag);
        int          sumw;
        logic [63:0] lb;
        lb = {a[63:5], 5'b0};
        while (dv_count == 0 && cyc < 400) step();
        b_rd = 1'b0;
        repeat (3) step();
        sumw = 0;
        foreach (waits_q[i]) sumw += waits_q[i];
        chki({tag, "_dv_cycle"}, dv_cycle, 1 + BEATS + sumw);
        chki({tag, "_dv_pulses"}, dv_count, 1);
        chk({tag, "_line"}, dv_data, model_line(a));
        chki({tag, "_beats"}, addr_q.size(), BEATS);
        for (int k = 0; k < BEATS && k < addr_q.size(); k++)
            chk64({tag, "_m_addr"}, addr_q[k], lb + 64'(8 * k));
        chki({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        clear();

        // Reset state
        #3;
        chki("rst_m_rd", int'(m_rd), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_b_dv", int'(b_dv), 0);
        chk64("rst_m_addr", m_addr, 64'h0);
        chk("rst_b_data", b_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait fill
        fixed_wait = 0;
        clear();
        b_addr = 64'h8000_0014;
        b_rd = 1'b1;
        finish_fill(64'h8000_0014, "zw");
        chki("zw_cycle5", dv_cycle, 5);
        chk64("zw_word0", dv_data[63:0], 64'h1111_1111_1111_1111);
        chk64("zw_word3", dv_data[255:192], 64'h4444_4444_4444_4444);

        // Three wait states per beat
        fixed_wait = 3;
        clear();
        b_addr = 64'h8000_0100;
        b_rd = 1'b1;
        finish_fill(64'h8000_0100, "ws");
        chki("ws_cycle17", dv_cycle, 17);

        // Drop b_rd in beat 2 while memory stalls; new request during DRAIN waits for IDLE
        fixed_wait = 2;
        clear();
        b_addr = 64'h8000_0000;
        b_rd = 1'b1;
        while (addr_q.size() < 2 && cyc < 100) step();
        b_rd = 1'b0;
        step();
        chki("drop_busy", int'(busy), 1);
        chki("drop_m_rd", int'(m_rd), 1);
        chk64("drop_m_addr", m_addr, 64'h8000_0010);
        b_rd = 1'b1;
        b_addr = 64'h9000_0020;
        while (busy && cyc < 100) step();
        chk64("drain_last_addr", addr_q[$], 64'h8000_0010);
        chki("drain_m_rd", int'(m_rd), 0);
        chki("drain_no_dv", dv_count, 0);
        clear();
        finish_fill(64'h9000_0020, "post_drain");

        // Address change in beat 1 together with m_dv
        fixed_wait = 0;
        clear();
        b_addr = 64'h8000_0000;
        b_rd = 1'b1;
        while (addr_q.size() < 1 && cyc < 100) step();
        b_addr = 64'h8000_0040;
        step();
        chki("achg_idle", int'(busy), 0);
        chki("achg_no_dv", dv_count, 0);
        clear();
        finish_fill(64'h8000_0040, "achg");

        // Abort collides with the last beat's m_dv
        clear();
        b_addr = 64'h8000_0200;
        b_rd = 1'b1;
        while (addr_q.size() < 3 && cyc < 100) step();
        b_rd = 1'b0;
        step();
        chki("coll_idle", int'(busy), 0);
        chk64("coll_beat3_seen", addr_q[$], 64'h8000_0218);
        repeat (3) step();
        chki("coll_no_dv", dv_count, 0);

        // Asynchronous reset in the middle of a stalled beat
        fixed_wait = 3;
        clear();
        b_addr = 64'h8000_0300;
        b_rd = 1'b1;
        repeat (3) step();
        chki("arst_pre_m_rd", int'(m_rd), 1);
        #2;
        rst = 1'b1;
        #1;
        chki("arst_m_rd", int'(m_rd), 0);
        chki("arst_busy", int'(busy), 0);
        chki("arst_b_dv", int'(b_dv), 0);
        chk64("arst_m_addr", m_addr, 64'h0);
        m_dv = 1'b0;
        loaded = 0;
        prev_wait = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fixed_wait = 0;
        clear();
        finish_fill(64'h8000_0300, "arst_restart");

        // Randomized fills with random waits and memory contents
        rand_waits = 1;
        for (int n = 0; n < 20; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            salt = {$urandom, $urandom};
            clear();
            b_addr = a;
            b_rd = 1'b1;
            finish_fill(a, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
